// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: halts and drains the pipeline, injects ITR instructions
// one at a time while halted, and resumes normal fetch on request.
module dbg_run_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_on_rst,
    input  logic        halt_req,
    input  logic        resume_req,
    input  logic        itr_valid,
    input  logic [31:0] itr_insn,
    output logic        itr_ready,
    input  logic        pipe_empty,
    input  logic        retire_valid,
    output logic        fetch_stall,
    output logic        fetch_itr_valid,
    output logic [31:0] fetch_itr_insn,
    output logic        halted,
    output logic        itr_timeout_err,
    input  logic        err_clr,
    output logic [7:0]  itr_count
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_RUN       = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_HALTED    = 3'd3,
        ST_ITR_ISSUE = 3'd4,
        ST_ITR_WAIT  = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] wait_cnt_r;
    logic                 itr_accept_s;
    logic                 itr_retire_s;
    logic                 itr_timeout_s;
    logic                 fetch_stall_s;
    logic                 halted_s;
    logic                 itr_ready_s;
    logic                 fetch_itr_valid_s;
    logic                 fetch_stall_r;
    logic                 halted_r;
    logic                 itr_ready_r;
    logic                 fetch_itr_valid_r;
    logic [31:0]          fetch_itr_insn_r;
    logic                 itr_timeout_err_r;
    logic [7:0]           itr_count_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an ITR offered together with resume takes priority
    always_comb begin
        state_next_s  = state_r;
        itr_accept_s  = 1'b0;
        itr_retire_s  = 1'b0;
        itr_timeout_s = 1'b0;
        case (state_r)
            ST_RESET: begin
                if (dbg_on_rst) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (itr_valid) begin
                    itr_accept_s = 1'b1;
                    state_next_s = ST_ITR_ISSUE;
                end else if (resume_req) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            ST_ITR_ISSUE: begin
                state_next_s = ST_ITR_WAIT;
            end
            ST_ITR_WAIT: begin
                if (retire_valid) begin
                    itr_retire_s = 1'b1;
                    state_next_s = ST_HALTED;
                end else if (wait_cnt_r == CNT_LAST) begin
                    itr_timeout_s = 1'b1;
                    state_next_s  = ST_HALTED;
                end else begin
                    state_next_s = ST_ITR_WAIT;
                end
            end
            default: begin
                state_next_s = ST_RESET;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        fetch_stall_s     = 1'b1;
        halted_s          = 1'b0;
        itr_ready_s       = 1'b0;
        fetch_itr_valid_s = 1'b0;
        case (state_next_s)
            ST_RUN: begin
                fetch_stall_s = 1'b0;
            end
            ST_HALTED: begin
                halted_s    = 1'b1;
                itr_ready_s = 1'b1;
            end
            ST_ITR_ISSUE: begin
                halted_s          = 1'b1;
                fetch_itr_valid_s = 1'b1;
            end
            ST_ITR_WAIT: begin
                halted_s = 1'b1;
            end
            default: begin
                fetch_stall_s = 1'b1;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_stall_r     <= 1'b1;
            halted_r          <= 1'b0;
            itr_ready_r       <= 1'b0;
            fetch_itr_valid_r <= 1'b0;
        end else begin
            fetch_stall_r     <= fetch_stall_s;
            halted_r          <= halted_s;
            itr_ready_r       <= itr_ready_s;
            fetch_itr_valid_r <= fetch_itr_valid_s;
        end
    end

    // ITR wait counter: cleared on issue, counts every cycle spent waiting for retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (state_r == ST_ITR_WAIT) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {CNT_WIDTH{1'b0}};
        end
    end

    // Injected instruction latch, held stable until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_itr_insn_r <= 32'h0000_0000;
        end else if (itr_accept_s) begin
            fetch_itr_insn_r <= itr_insn;
        end else begin
            fetch_itr_insn_r <= fetch_itr_insn_r;
        end
    end

    // Sticky timeout flag: a new timeout outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itr_timeout_err_r <= 1'b0;
        end else if (itr_timeout_s) begin
            itr_timeout_err_r <= 1'b1;
        end else if (err_clr) begin
            itr_timeout_err_r <= 1'b0;
        end else begin
            itr_timeout_err_r <= itr_timeout_err_r;
        end
    end

    // Retired ITR counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itr_count_r <= 8'd0;
        end else if (itr_retire_s) begin
            itr_count_r <= itr_count_r + 8'd1;
        end else begin
            itr_count_r <= itr_count_r;
        end
    end

    assign fetch_stall     = fetch_stall_r;
    assign halted          = halted_r;
    assign itr_ready       = itr_ready_r;
    assign fetch_itr_valid = fetch_itr_valid_r;
    assign fetch_itr_insn  = fetch_itr_insn_r;
    assign itr_timeout_err = itr_timeout_err_r;
    assign itr_count       = itr_count_r;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Scoreboard bench for dbg_run_ctrl: directed halt/ITR/resume/timeout/reset sequences.
module tb_dbg_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_on_rst;
    logic        halt_req;
    logic        resume_req;
    logic        itr_valid;
    logic [31:0] itr_insn;
    logic        itr_ready;
    logic        pipe_empty;
    logic        retire_valid;
    logic        fetch_stall;
    logic        fetch_itr_valid;
    logic [31:0] fetch_itr_insn;
    logic        halted;
    logic        itr_timeout_err;
    logic        err_clr;
    logic [7:0]  itr_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       err;
    } done_t;

    logic [31:0] inj_q[$];
    done_t       done_q[$];
    logic        outstanding = 1'b0;
    logic        prev_ready  = 1'b0;
    logic        prev_fv     = 1'b0;

    dbg_run_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .dbg_on_rst      (dbg_on_rst),
        .halt_req        (halt_req),
        .resume_req      (resume_req),
        .itr_valid       (itr_valid),
        .itr_insn        (itr_insn),
        .itr_ready       (itr_ready),
        .pipe_empty      (pipe_empty),
        .retire_valid    (retire_valid),
        .fetch_stall     (fetch_stall),
        .fetch_itr_valid (fetch_itr_valid),
        .fetch_itr_insn  (fetch_itr_insn),
        .halted          (halted),
        .itr_timeout_err (itr_timeout_err),
        .err_clr         (err_clr),
        .itr_count       (itr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, {31'd0, fetch_stall}, 32'd1);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_ready"}, {31'd0, itr_ready}, 32'd0);
        chk({tag, "_fv"}, {31'd0, fetch_itr_valid}, 32'd0);
        chk({tag, "_insn"}, fetch_itr_insn, 32'd0);
        chk({tag, "_err"}, {31'd0, itr_timeout_err}, 32'd0);
        chk({tag, "_count"}, {24'd0, itr_count}, 32'd0);
    endtask

    task automatic offer_itr(input logic [31:0] insn, input logic with_resume);
        itr_insn   = insn;
        itr_valid  = 1'b1;
        resume_req = with_resume;
        inj_q.push_back(insn);
        step(1);
        itr_valid  = 1'b0;
        resume_req = 1'b0;
    endtask

    // Monitor: compares injections and ITR completions against the scoreboard queues
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            prev_ready  = 1'b0;
            prev_fv     = 1'b0;
        end else begin
            if (fetch_itr_valid) begin
                if (prev_fv) begin
                    chk("inj_pulse_width", 32'd2, 32'd1);
                end
                if (inj_q.size() == 0) begin
                    chk("inj_unexpected", fetch_itr_insn, 32'd0);
                end else begin
                    chk("inj_insn", fetch_itr_insn, inj_q.pop_front());
                end
                outstanding = 1'b1;
            end
            if (outstanding && itr_ready && !prev_ready) begin
                outstanding = 1'b0;
                if (done_q.size() == 0) begin
                    chk("done_unexpected", {24'd0, itr_count}, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_count", {24'd0, itr_count}, {24'd0, d.cnt});
                    chk("done_err", {31'd0, itr_timeout_err}, {31'd0, d.err});
                end
            end
            prev_ready = itr_ready;
            prev_fv    = fetch_itr_valid;
        end
    end

    initial begin
        rst = 1'b1; dbg_on_rst = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
        itr_valid = 1'b0; itr_insn = 32'd0; pipe_empty = 1'b0;
        retire_valid = 1'b0; err_clr = 1'b0;

        // Reset values, then one RESET cycle into RUN
        step(2);
        chk_reset_vals("rst0");
        rst = 1'b0;
        chk("reset_cycle_stall", {31'd0, fetch_stall}, 32'd1);
        step(1);
        chk("run_stall", {31'd0, fetch_stall}, 32'd0);
        chk("run_halted", {31'd0, halted}, 32'd0);

        // Halt with a 5-cycle drain
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        chk("drain_stall_n1", {31'd0, fetch_stall}, 32'd1);
        chk("drain_halted_n1", {31'd0, halted}, 32'd0);
        step(5);
        chk("drain_still", {31'd0, halted}, 32'd0);
        pipe_empty = 1'b1;
        step(1);
        chk("halted_n7", {31'd0, halted}, 32'd1);
        chk("halted_ready", {31'd0, itr_ready}, 32'd1);

        // ITR retiring three edges after accept
        done_q.push_back('{cnt: 8'd1, err: 1'b0});
        offer_itr(32'h0050_0093, 1'b0);
        chk("issue_ready", {31'd0, itr_ready}, 32'd0);
        chk("issue_halted", {31'd0, halted}, 32'd1);
        step(2);
        retire_valid = 1'b1;
        step(1);
        retire_valid = 1'b0;
        chk("itr1_count", {24'd0, itr_count}, 32'd1);

        // Stray retire and halt_req while halted have no effect
        retire_valid = 1'b1;
        halt_req     = 1'b1;
        step(1);
        retire_valid = 1'b0;
        halt_req     = 1'b0;
        step(1);
        chk("stray_retire_count", {24'd0, itr_count}, 32'd1);
        chk("halt_in_halted", {31'd0, halted}, 32'd1);

        // ITR timeout exactly after 64 wait cycles, then clear
        done_q.push_back('{cnt: 8'd1, err: 1'b1});
        offer_itr(32'hDEAD_BEEF, 1'b0);
        step(64);
        chk("timeout_not_yet_err", {31'd0, itr_timeout_err}, 32'd0);
        chk("timeout_not_yet_rdy", {31'd0, itr_ready}, 32'd0);
        step(1);
        chk("timeout_err", {31'd0, itr_timeout_err}, 32'd1);
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("err_cleared", {31'd0, itr_timeout_err}, 32'd0);

        // ITR and resume together: ITR wins, resume dropped
        done_q.push_back('{cnt: 8'd2, err: 1'b0});
        offer_itr(32'h0010_0073, 1'b1);
        chk("itr_vs_resume_halted", {31'd0, halted}, 32'd1);
        step(1);
        retire_valid = 1'b1;
        step(1);
        retire_valid = 1'b0;
        step(1);
        chk("resume_dropped_stall", {31'd0, fetch_stall}, 32'd1);
        chk("itr3_count", {24'd0, itr_count}, 32'd2);

        // Resume, then halt with pipe already empty (still one DRAIN cycle)
        resume_req = 1'b1;
        step(1);
        resume_req = 1'b0;
        chk("resume_stall", {31'd0, fetch_stall}, 32'd0);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        chk("min_drain_halted", {31'd0, halted}, 32'd0);
        chk("min_drain_stall", {31'd0, fetch_stall}, 32'd1);
        step(1);
        chk("min_drain_done", {31'd0, halted}, 32'd1);

        // Reset in the middle of ITR_WAIT, then restart halted via dbg_on_rst
        offer_itr(32'h1234_5678, 1'b0);
        step(3);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        dbg_on_rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        chk("dbg_rst_halted", {31'd0, halted}, 32'd1);
        chk("dbg_rst_ready", {31'd0, itr_ready}, 32'd1);
        chk("dbg_rst_stall", {31'd0, fetch_stall}, 32'd1);
        chk("dbg_rst_count", {24'd0, itr_count}, 32'd0);

        step(2);
        chk("inj_q_empty", inj_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
